// File: rtl/data_mem_subword.sv
// RV32 data memory with byte/half/word loads and stores, sign/zero extension,
// alignment/range fault detection and a req/ready/done handshake with a
// configurable read latency.
module data_mem_subword #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              data_i,
  output logic                     ready,
  output logic                     done,
  output logic                     fault,
  output logic [31:0]              data_o,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] data_q;
  logic [31:0] pend_data_q;
  logic        pend_fault_q;

  // Not reset: contents survive rst.
  logic [31:0] mem_q [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          accept;
  logic          range_err;
  logic          align_err;
  logic          f3_err;
  logic          acc_fault;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ld_res;

  assign ready     = (state_q == StIdle);
  assign accept    = req & ready;
  assign off       = addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign lane      = addr[1:0];
  assign range_err = (addr < BASE_ADDR) | ((off >> 2) >= DEPTH);
  assign acc_fault = range_err | align_err | f3_err;

  // Width decode: byte enables, replicated store data, alignment and funct3 checks.
  always_comb begin
    be        = 4'b0000;
    wdata     = data_i;
    align_err = 1'b0;
    f3_err    = 1'b0;
    case (funct3)
      3'b000, 3'b100: begin
        be     = 4'b0001 << lane;
        wdata  = {4{data_i[7:0]}};
        f3_err = we & funct3[2];
      end
      3'b001, 3'b101: begin
        be        = 4'b0011 << lane;
        wdata     = {2{data_i[15:0]}};
        align_err = lane[0];
        f3_err    = we & funct3[2];
      end
      3'b010: begin
        be        = 4'b1111;
        align_err = |lane;
      end
      default: f3_err = 1'b1;
    endcase
  end

  assign rword = mem_q[idx];
  assign rbyte = 8'(rword >> {lane, 3'b000});
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  // Load result extension; a faulting access always yields zero.
  always_comb begin
    ld_res = rword;
    case (funct3)
      3'b000:  ld_res = {{24{rbyte[7]}}, rbyte};
      3'b100:  ld_res = {24'h0, rbyte};
      3'b001:  ld_res = {{16{rhalf[15]}}, rhalf};
      3'b101:  ld_res = {16'h0, rhalf};
      default: ld_res = rword;
    endcase
    if (acc_fault) begin
      ld_res = 32'h0;
    end
  end

  // Store commit at the accept edge; suppressed on fault or reset.
  always_ff @(posedge clk) begin
    if (!rst && accept && we && !acc_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Handshake FSM: stores and single-cycle loads complete directly from IDLE,
  // longer loads wait in BUSY and complete on the same edge that frees ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      data_q       <= 32'h0;
      pend_data_q  <= 32'h0;
      pend_fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (we || (RD_LAT == 1)) begin
              done_q  <= 1'b1;
              fault_q <= acc_fault;
              if (!we) begin
                data_q <= ld_res;
              end
            end else begin
              state_q      <= StBusy;
              cnt_q        <= 3'(RD_LAT - 1);
              pend_data_q  <= ld_res;
              pend_fault_q <= acc_fault;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 3'd1) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            fault_q <= pend_fault_q;
            data_q  <= pend_data_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
      endcase
    end
  end

  assign done     = done_q;
  assign fault    = fault_q;
  assign data_o   = data_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule
